interval_timer_ctrl: RTL and testbench

//   Sequences an N-bit up-counter as a programmable interval timer.
//   - Internal prescaler produces a counter enable every 2^PRESCALE_W clocks.
//   - FSM accepts start/pause/clear pulses from debounced buttons or a host.
//   - Stops the count at a latched limit.
//   - Drives seven-segment / LED status logic.

---
 rtl/interval_timer_ctrl.sv | 127 ++++++++++++
 tb/tb_interval_timer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - programmable interval timer: prescaled up-counter sequenced by a start/pause/clear FSM
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    1-cycle pulse: begin from IDLE/DONE, resume from PAUSE
//   pause    1-cycle pulse: freeze count and prescaler while running
//   clear    1-cycle pulse: abort to IDLE with count and prescaler zeroed
//   limit    terminal count, latched only when a start launches from IDLE/DONE
//   count    current main count
//   state    IDLE=00 RUN=01 PAUSE=10 DONE=11
//   running  high while in RUN
//   tick     pulses the cycle after each count increment
//   done     pulses on the first cycle in DONE
module interval_timer_ctrl #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         clear,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic [1:0]   state,
    output logic         running,
    output logic         tick,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          count_q, count_d;
    logic [N-1:0]          limit_q, limit_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  tick_d, done_d;
    logic [N-1:0]          count_inc;

    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
            pre_q   <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            pre_q   <= pre_d;
            tick    <= tick_d;
            done    <= done_d;
            // Registered from the next state so running stays aligned with state.
            running <= (state_d == S_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count_d = '0;
                        pre_d   = '0;
                        if (limit == '0) begin
                            // Zero-length interval finishes immediately.
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            limit_d = limit;
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // A start in RUN is ignored but still outranks pause, so
                    // start+pause together leaves the timer counting.
                    if (pause && !start) begin
                        // Holding the prescaler here also swallows a step that
                        // would have landed on this edge.
                        state_d = S_PAUSE;
                    end else begin
                        pre_d = pre_q + 1'b1;
                        if (pre_q == {PRESCALE_W{1'b1}}) begin
                            count_d = count_inc;
                            tick_d  = 1'b1;
                            if (count_inc == limit_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (start) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign count = count_q;
    assign state = state_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - self-checking bench for interval_timer_ctrl with directed and random scenarios
module tb_interval_timer_ctrl;

    localparam int N    = 8;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [N-1:0] limit = '0;
    logic [N-1:0] count;
    logic [1:0]   state;
    logic         running, tick, done;

    int checks = 0;
    int errors = 0;

    // Reference model: timer described by its observable quantities.
    int m_st, m_cnt, m_pre, m_lim;
    bit m_tick, m_done;

    interval_timer_ctrl #(.N(N), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .limit(limit), .count(count), .state(state), .running(running),
        .tick(tick), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_pre = 0; m_lim = 0; m_tick = 0; m_done = 0;
    endtask

    // One clock edge of the timer rules: clear > start > pause.
    task automatic model_edge(input bit s, input bit p, input bit c, input int lim_in);
        m_tick = 0; m_done = 0;
        if (c) begin
            m_st = 0; m_cnt = 0; m_pre = 0;
        end else if (s && (m_st == 0 || m_st == 3)) begin
            m_cnt = 0; m_pre = 0;
            if (lim_in == 0) begin m_st = 3; m_done = 1; end
            else begin m_lim = lim_in; m_st = 1; end
        end else if (s && m_st == 2) begin
            m_st = 1;
        end else if (m_st == 1 && p && !s) begin
            m_st = 2;
        end else if (m_st == 1) begin
            if (m_pre == PMAX) begin
                m_cnt = m_cnt + 1; m_tick = 1;
                if (m_cnt == m_lim) begin m_st = 3; m_done = 1; end
            end
            m_pre = (m_pre + 1) % (PMAX + 1);
        end
    endtask

    // Drive pulses for one edge, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input bit s, input bit p, input bit c);
        start = s; pause = p; clear = c;
        @(posedge clk);
        model_edge(s, p, c, int'(limit));
        #1;
        start = 0; pause = 0; clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'b00 || count !== 0 || tick !== 0 || done !== 0 || running !== 0) begin
            errors++; $display("FAIL reset_init: state=%0d count=%0d tick=%0d done=%0d running=%0d, want all 0", state, count, tick, done, running);
        end
        limit = 8'd5;
        cyc(1, 0, 0);
        idle(8);
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL reset_pre_count: count=%0d want 2", count); end
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (state !== 2'b00 || count !== 0 || tick !== 0 || done !== 0 || running !== 0) begin
            errors++; $display("FAIL reset_async: state=%0d count=%0d tick=%0d done=%0d running=%0d, want all 0", state, count, tick, done, running);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic_count();
        int ticks = 0;
        limit = 8'd3;
        cyc(1, 0, 0);
        for (int e = 1; e <= 12; e++) begin
            cyc(0, 0, 0);
            if (tick) ticks++;
            checks++; if (count !== N'(e / 4)) begin errors++; $display("FAIL basic_count@%0d: count=%0d want %0d", e, count, e / 4); end
        end
        checks++; if (state !== 2'b11 || done !== 1'b1) begin errors++; $display("FAIL basic_done: state=%0d done=%0d want 3/1", state, done); end
        checks++; if (ticks != 3) begin errors++; $display("FAIL basic_ticks: ticks=%0d want 3", ticks); end
        cyc(0, 1, 0);
        checks++; if (state !== 2'b11 || done !== 1'b0 || count !== 8'd3) begin
            errors++; $display("FAIL done_hold: state=%0d done=%0d count=%0d want 3/0/3", state, done, count);
        end
    endtask

    task automatic test_pause_resume();
        cyc(0, 0, 1);
        limit = 8'd5;
        cyc(1, 0, 0);
        idle(9);                 // count=2 after edge 8, prescaler=1 after edge 9
        cyc(0, 1, 0);            // prescaler held at 1
        checks++; if (state !== 2'b10 || count !== 8'd2) begin errors++; $display("FAIL pause_enter: state=%0d count=%0d want 2/2", state, count); end
        for (int i = 0; i < 20; i++) begin
            cyc(0, (i % 3) == 0, 0);
            checks++; if (count !== 8'd2 || state !== 2'b10) begin errors++; $display("FAIL pause_hold@%0d: count=%0d state=%0d", i, count, state); end
        end
        cyc(1, 0, 0);
        checks++; if (state !== 2'b01 || running !== 1'b1) begin errors++; $display("FAIL resume: state=%0d running=%0d", state, running); end
        // Held prescaler 1 needs RUN cycles at 1,2,3 before the step.
        for (int e = 1; e <= PMAX + 1 - 1; e++) begin
            cyc(0, 0, 0);
            checks++; if (count !== (e < PMAX ? 8'd2 : 8'd3)) begin errors++; $display("FAIL resume_step@%0d: count=%0d", e, count); end
        end
    endtask

    task automatic test_priority();
        cyc(0, 0, 1);
        limit = 8'd5;
        cyc(1, 0, 0);
        idle(5);
        cyc(1, 0, 1);
        checks++; if (state !== 2'b00 || count !== 0 || running !== 0) begin errors++; $display("FAIL start_clear: state=%0d count=%0d", state, count); end
        cyc(1, 0, 0);
        idle(3);                 // prescaler at all-ones before next edge
        cyc(0, 1, 0);            // step pre-empted by pause
        checks++; if (state !== 2'b10 || count !== 0 || tick !== 0) begin errors++; $display("FAIL pause_on_step: state=%0d count=%0d tick=%0d", state, count, tick); end
        cyc(1, 1, 0);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_pause_in_pause: state=%0d want 1", state); end
        cyc(0, 0, 0);            // held all-ones prescaler steps immediately
        checks++; if (count !== 8'd1 || tick !== 1'b1) begin errors++; $display("FAIL step_after_resume: count=%0d tick=%0d want 1/1", count, tick); end
    endtask

    task automatic test_zero_limit();
        cyc(0, 0, 1);
        limit = 8'd0;
        cyc(1, 0, 0);
        checks++; if (state !== 2'b11 || done !== 1'b1 || count !== 0) begin errors++; $display("FAIL zero_limit: state=%0d done=%0d count=%0d", state, done, count); end
        cyc(0, 0, 0);
        checks++; if (done !== 1'b0 || state !== 2'b11) begin errors++; $display("FAIL zero_limit_once: done=%0d state=%0d", done, state); end
    endtask

    task automatic test_relatch();
        cyc(0, 0, 1);
        limit = 8'd3;
        cyc(1, 0, 0);
        idle(12);
        checks++; if (state !== 2'b11 || count !== 8'd3) begin errors++; $display("FAIL relatch_pre: state=%0d count=%0d", state, count); end
        limit = 8'd1;
        cyc(1, 0, 0);
        checks++; if (state !== 2'b01 || count !== 0) begin errors++; $display("FAIL relatch_start: state=%0d count=%0d", state, count); end
        limit = 8'd200;
        idle(4);
        checks++; if (state !== 2'b11 || count !== 8'd1) begin errors++; $display("FAIL relatch_done: state=%0d count=%0d want 3/1", state, count); end
    endtask

    task automatic test_full_limit();
        int hit = 0;
        cyc(0, 0, 1);
        limit = 8'hFF;
        cyc(1, 0, 0);
        for (int e = 1; e <= 255 * (PMAX + 1) + 4; e++) begin
            cyc(0, 0, 0);
            if (done) hit = e;
        end
        checks++; if (hit != 255 * (PMAX + 1)) begin errors++; $display("FAIL full_limit_done_edge: edge=%0d want %0d", hit, 255 * (PMAX + 1)); end
        checks++; if (count !== 8'hFF || state !== 2'b11) begin errors++; $display("FAIL full_limit_hold: count=%0d state=%0d", count, state); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) limit = N'($urandom_range(0, 6));
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
            checks++;
            if (state !== 2'(m_st) || count !== N'(m_cnt) || running !== (m_st == 1) || tick !== m_tick || done !== m_done) begin
                errors++;
                $display("FAIL random@%0d: state=%0d count=%0d run=%0d tick=%0d done=%0d want %0d/%0d/%0d/%0d/%0d",
                         i, state, count, running, tick, done, m_st, m_cnt, m_st == 1, m_tick, m_done);
            end
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_priority();
        test_zero_limit();
        test_relatch();
        test_full_limit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
